eth_tx_sched: RTL and testbench
===============================

# eth_tx_sched

Transmit scheduler sharing the single Ethernet TX frame builder between ARP replies and ICMP echo replies. Latches ARP reply requests and queues decoded ICMP echo requests (id, sequence number) from the ICMP receive parser. Grants the TX builder round-robin, one frame at a time. Enforces a frame-completion timeout and an inter-frame gap. Sits between the RX protocol parsers and the TX frame builder.

## Interface
Parameters:
- ICMP_DEPTH, 4, ICMP request queue entries (power of 2, ≥2)
- IFG_CYCLES, 12, idle cycles after each frame (≥1)
- TIMEOUT_CYCLES, 4096, max cycles from tx_start to tx_done (≥2)

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- arp_reply_req  in  1  one-cycle pulse: ARP reply needed
- icmp_request_done  in  1  one-cycle pulse: valid echo request parsed
- icmp_id  in  16  echo identifier, valid with icmp_request_done
- icmp_seq_num  in  16  echo sequence number, valid with icmp_request_done
- tx_start  out  1  one-cycle pulse: begin frame
- tx_sel  out  2  frame type: 0 none, 1 ARP, 2 ICMP
- tx_icmp_id  out  16  id for ICMP frame
- tx_icmp_seq_num  out  16  sequence number for ICMP frame
- tx_done  in  1  one-cycle pulse from builder: frame sent
- tx_timeout  out  1  one-cycle pulse: frame aborted on timeout
- icmp_pending  out  $clog2(ICMP_DEPTH+1)  queued ICMP requests
- drop_cnt  out  8  saturating count of dropped requests

## Operation
- ARP: single pending flag. Set on arp_reply_req. Cleared on ARP grant. A pulse while the flag is set is dropped (drop_cnt +1).
- ICMP: FIFO of {id, seq}. Push on icmp_request_done. When full, the request is dropped (drop_cnt +1), unless a pop occurs in the same cycle; in that case the push is accepted.
- drop_cnt saturates at 255. An ARP drop and an ICMP drop in the same cycle add 2.
- FSM states: IDLE, START, WAIT_DONE, GAP.
  - IDLE → START when any request is pending. Selects the grant, pops the FIFO or clears the ARP flag, and registers tx_sel, tx_icmp_id and tx_icmp_seq_num.
  - START: tx_start=1 for this single cycle, then → WAIT_DONE. The timeout counter clears.
  - WAIT_DONE → GAP on tx_done. Also → GAP with a tx_timeout pulse once the counter reaches TIMEOUT_CYCLES. A timed-out request is discarded, not retried.
  - GAP: counts IFG_CYCLES cycles, then → IDLE. tx_sel returns to 0 on entering GAP.
- Arbitration: round-robin via a last_grant bit. When both sources are pending, the source not last granted wins. Reset value of last_grant = ICMP, so ARP wins the first tie. A single pending source always wins.
- tx_done outside WAIT_DONE is ignored. If tx_done arrives in the same cycle the timeout is reached, tx_done wins and no tx_timeout is issued.

## Timing
- Reset values: tx_start=0, tx_sel=0, tx_icmp_id=0, tx_icmp_seq_num=0, tx_timeout=0, icmp_pending=0, drop_cnt=0, state=IDLE, FIFO empty, ARP flag clear.
- Reset mid-frame aborts immediately. Queued requests are flushed and no tx_timeout is issued.
- Request latency: a request pulse at cycle N, with the FSM IDLE and nothing else pending, gives tx_start at cycle N+2.
- tx_sel, tx_icmp_id and tx_icmp_seq_num are stable from the tx_start cycle through the tx_done (or timeout) cycle.
- Back-to-back frames: the next tx_start comes no earlier than IFG_CYCLES+2 cycles after tx_done.
- icmp_pending updates the cycle after a push or pop. A simultaneous push and pop leave it unchanged.

## Structure
- Shared package eth_pkg holds:
  - tx_sel_t enum: TX_NONE=0, TX_ARP=1, TX_ICMP=2.
  - the sched_state_t enum.
  - an icmp_req_t struct {id, seq}.
- Sub-module icmp_req_fifo: synchronous FIFO of icmp_req_t with push, pop, full, empty and count outputs, parameterised by depth.

## Test plan
- Single ARP pulse at cycle 10 → tx_start at cycle 12 with tx_sel=1. tx_done at cycle 20 → next grant possible no earlier than cycle 34 (IFG=12).
- ICMP request id=0x1234, seq=0x0001 → tx_start with tx_sel=2, tx_icmp_id=0x1234, tx_icmp_seq_num=0x0001, held until tx_done.
- ARP and ICMP pulses in the same cycle after reset → ARP frame first, then ICMP. Repeated dual load alternates 1, 2, 1, 2.
- Five ICMP pulses while the builder is busy (depth 4) → icmp_pending=4, drop_cnt=1. Frames go out in FIFO order with seq 1..4.
- Never assert tx_done → tx_timeout pulse exactly TIMEOUT_CYCLES cycles after tx_start. The queue then advances to the next request after the gap.
- Assert aresetn low during WAIT_DONE with 3 queued requests → all outputs return to reset values at once. No tx_start after release until a new request arrives.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared types for the Ethernet TX scheduling slice: frame selector, scheduler
// state encoding, queued ICMP echo request record and a saturating counter helper.
package eth_pkg;

  typedef enum logic [1:0] {
    TX_NONE = 2'd0,
    TX_ARP  = 2'd1,
    TX_ICMP = 2'd2
  } tx_sel_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic [15:0] id;
    logic [15:0] seq;
  } icmp_req_t;

  // Adds 0..2 to an 8-bit count, clamping at 255.
  function automatic logic [7:0] sat_add8(input logic [7:0] base, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, base} + {7'd0, inc};
    return (sum > 9'd255) ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/icmp_req_fifo.sv
// Synchronous FIFO of decoded ICMP echo requests. When full, a pop in the same
// cycle frees the slot so a simultaneous push is still accepted.
module icmp_req_fifo
  import eth_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       push,
  input  icmp_req_t                  push_data,
  input  logic                       pop,
  output icmp_req_t                  pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  icmp_req_t     mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  // Qualify push and pop against current occupancy
  always_comb begin
    pop_ok_s  = pop && (count_r != '0);
    push_ok_s = push && ((count_r != CW'(DEPTH)) || pop_ok_s);
  end

  // Storage, pointers and occupancy count
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Status and head-of-queue view
  always_comb begin
    pop_data = mem_r[rd_ptr_r];
    full     = (count_r == CW'(DEPTH));
    empty    = (count_r == '0);
    count    = count_r;
  end

endmodule

// File: rtl/eth_tx_sched.sv
// Transmit scheduler: shares the single TX frame builder between ARP replies and
// queued ICMP echo replies, round-robin, with a completion timeout and inter-frame gap.
module eth_tx_sched
  import eth_pkg::*;
#(
  parameter int ICMP_DEPTH     = 4,
  parameter int IFG_CYCLES     = 12,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic                            arp_reply_req,
  input  logic                            icmp_request_done,
  input  logic [15:0]                     icmp_id,
  input  logic [15:0]                     icmp_seq_num,
  output logic                            tx_start,
  output logic [1:0]                      tx_sel,
  output logic [15:0]                     tx_icmp_id,
  output logic [15:0]                     tx_icmp_seq_num,
  input  logic                            tx_done,
  output logic                            tx_timeout,
  output logic [$clog2(ICMP_DEPTH+1)-1:0] icmp_pending,
  output logic [7:0]                      drop_cnt
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = $clog2(IFG_CYCLES + 1);

  sched_state_t state_r;
  tx_sel_t      tx_sel_r;
  logic         tx_start_r;
  logic         tx_timeout_r;
  logic [15:0]  tx_id_r;
  logic [15:0]  tx_seq_r;
  logic [TMO_W-1:0] tmo_cnt_r;
  logic [GAP_W-1:0] gap_cnt_r;
  logic         arp_pend_r;
  logic         last_icmp_r;
  logic [7:0]   drop_cnt_r;

  icmp_req_t    push_req_s;
  icmp_req_t    head_req_s;
  logic         fifo_full_s;
  logic         fifo_empty_s;
  logic         grant_arp_s;
  logic         grant_icmp_s;
  logic         arp_drop_s;
  logic         icmp_drop_s;

  // Pack the parsed echo request for queueing
  always_comb begin
    push_req_s.id  = icmp_id;
    push_req_s.seq = icmp_seq_num;
  end

  icmp_req_fifo #(
    .DEPTH (ICMP_DEPTH)
  ) u_icmp_fifo (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .push      (icmp_request_done),
    .push_data (push_req_s),
    .pop       (grant_icmp_s),
    .pop_data  (head_req_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (icmp_pending)
  );

  // Round-robin grant: on a tie the source not granted last time wins
  always_comb begin
    grant_arp_s  = 1'b0;
    grant_icmp_s = 1'b0;
    if (state_r == ST_IDLE) begin
      if (arp_pend_r && !fifo_empty_s) begin
        grant_arp_s  = last_icmp_r;
        grant_icmp_s = !last_icmp_r;
      end else begin
        grant_arp_s  = arp_pend_r;
        grant_icmp_s = !fifo_empty_s;
      end
    end else begin
      grant_arp_s  = 1'b0;
      grant_icmp_s = 1'b0;
    end
  end

  // Drop detection; a grant in the same cycle makes room for the new request
  always_comb begin
    arp_drop_s  = arp_reply_req && arp_pend_r && !grant_arp_s;
    icmp_drop_s = icmp_request_done && fifo_full_s && !grant_icmp_s;
  end

  // ARP pending flag and saturating drop counter
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      arp_pend_r <= 1'b0;
      drop_cnt_r <= 8'd0;
    end else begin
      if (arp_reply_req) begin
        arp_pend_r <= 1'b1;
      end else if (grant_arp_s) begin
        arp_pend_r <= 1'b0;
      end
      drop_cnt_r <= sat_add8(drop_cnt_r, {1'b0, arp_drop_s} + {1'b0, icmp_drop_s});
    end
  end

  // Scheduler FSM with registered builder-facing outputs
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r      <= ST_IDLE;
      tx_start_r   <= 1'b0;
      tx_sel_r     <= TX_NONE;
      tx_id_r      <= 16'd0;
      tx_seq_r     <= 16'd0;
      tx_timeout_r <= 1'b0;
      tmo_cnt_r    <= '0;
      gap_cnt_r    <= '0;
      last_icmp_r  <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_arp_s || grant_icmp_s) begin
            state_r     <= ST_START;
            tx_start_r  <= 1'b1;
            tmo_cnt_r   <= '0;
            last_icmp_r <= grant_icmp_s;
            if (grant_icmp_s) begin
              tx_sel_r <= TX_ICMP;
              tx_id_r  <= head_req_s.id;
              tx_seq_r <= head_req_s.seq;
            end else begin
              tx_sel_r <= TX_ARP;
              tx_id_r  <= 16'd0;
              tx_seq_r <= 16'd0;
            end
          end
        end
        ST_START: begin
          tx_start_r <= 1'b0;
          tmo_cnt_r  <= tmo_cnt_r + TMO_W'(1);
          state_r    <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          // tmo_cnt_r equals cycles since tx_start; the pulse lands exactly TIMEOUT_CYCLES after it
          if (tx_done) begin
            state_r   <= ST_GAP;
            tx_sel_r  <= TX_NONE;
            gap_cnt_r <= '0;
          end else if (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            state_r      <= ST_GAP;
            tx_sel_r     <= TX_NONE;
            tx_timeout_r <= 1'b1;
            gap_cnt_r    <= '0;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
          end
        end
        ST_GAP: begin
          tx_timeout_r <= 1'b0;
          if (gap_cnt_r == GAP_W'(IFG_CYCLES - 1)) begin
            state_r <= ST_IDLE;
          end else begin
            gap_cnt_r <= gap_cnt_r + GAP_W'(1);
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          tx_start_r <= 1'b0;
          tx_sel_r   <= TX_NONE;
        end
      endcase
    end
  end

  // Output drive
  always_comb begin
    tx_start        = tx_start_r;
    tx_sel          = tx_sel_r;
    tx_icmp_id      = tx_id_r;
    tx_icmp_seq_num = tx_seq_r;
    tx_timeout      = tx_timeout_r;
    drop_cnt        = drop_cnt_r;
  end

endmodule

// File: tb/tb_eth_tx_sched.sv
// Scoreboard bench for eth_tx_sched: a transaction-level model predicts grants,
// timeouts, queue depth and drops; a monitor compares them against the DUT.
module tb_eth_tx_sched;

  localparam int DEPTH = 4;
  localparam int IFG   = 12;
  localparam int TMO   = 64;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        arp_reply_req = 1'b0;
  logic        icmp_request_done = 1'b0;
  logic [15:0] icmp_id = 16'd0;
  logic [15:0] icmp_seq_num = 16'd0;
  logic        tx_done = 1'b0;
  logic        tx_start;
  logic [1:0]  tx_sel;
  logic [15:0] tx_icmp_id;
  logic [15:0] tx_icmp_seq_num;
  logic        tx_timeout;
  logic [2:0]  icmp_pending;
  logic [7:0]  drop_cnt;

  eth_tx_sched #(
    .ICMP_DEPTH     (DEPTH),
    .IFG_CYCLES     (IFG),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .arp_reply_req     (arp_reply_req),
    .icmp_request_done (icmp_request_done),
    .icmp_id           (icmp_id),
    .icmp_seq_num      (icmp_seq_num),
    .tx_start          (tx_start),
    .tx_sel            (tx_sel),
    .tx_icmp_id        (tx_icmp_id),
    .tx_icmp_seq_num   (tx_icmp_seq_num),
    .tx_done           (tx_done),
    .tx_timeout        (tx_timeout),
    .icmp_pending      (icmp_pending),
    .drop_cnt          (drop_cnt)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int cyc;
    int sel;
    int id;
    int seq;
  } exp_t;

  exp_t exp_q[$];
  int   tmo_q[$];
  int   mq_id[$];
  int   mq_seq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  bit m_arp = 1'b0;
  bit m_last_icmp = 1'b1;
  bit m_busy = 1'b0;
  int m_start = 0;
  int m_free_at = 0;
  int m_drop = 0;
  int m_sel_now = 0;
  int m_id_now = 0;
  int m_seq_now = 0;

  int done_mode = 0;
  int done_fixed = 5;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq_id.delete();
    mq_seq.delete();
    exp_q.delete();
    tmo_q.delete();
    m_arp = 1'b0;
    m_last_icmp = 1'b1;
    m_busy = 1'b0;
    m_free_at = 0;
    m_drop = 0;
    m_sel_now = 0;
  endtask

  // One cycle of the reference model: arbitration, frame end, then new requests
  task automatic model_step(input int c);
    bit   ga;
    bit   gi;
    int   drops;
    exp_t e;
    ga = 1'b0;
    gi = 1'b0;
    if (!m_busy && c >= m_free_at && (m_arp || mq_id.size() > 0)) begin
      if (m_arp && mq_id.size() > 0) begin
        ga = m_last_icmp;
        gi = !m_last_icmp;
      end else begin
        ga = m_arp;
        gi = !m_arp;
      end
      e.cyc = c + 1;
      if (gi) begin
        e.sel = 2;
        e.id  = mq_id.pop_front();
        e.seq = mq_seq.pop_front();
        m_last_icmp = 1'b1;
      end else begin
        e.sel = 1;
        e.id  = 0;
        e.seq = 0;
        m_arp = 1'b0;
        m_last_icmp = 1'b0;
      end
      exp_q.push_back(e);
      m_busy = 1'b1;
      m_start = c + 1;
      m_sel_now = e.sel;
      m_id_now = e.id;
      m_seq_now = e.seq;
    end else if (m_busy && c > m_start) begin
      if (tx_done || (c - m_start == TMO - 1)) begin
        if (!tx_done) tmo_q.push_back(c + 1);
        m_busy = 1'b0;
        m_free_at = c + 1 + IFG;
        m_sel_now = 0;
      end
    end
    drops = 0;
    if (arp_reply_req) begin
      if (m_arp) drops++;
      else m_arp = 1'b1;
    end
    if (icmp_request_done) begin
      if (mq_id.size() < DEPTH) begin
        mq_id.push_back(int'(icmp_id));
        mq_seq.push_back(int'(icmp_seq_num));
      end else begin
        drops++;
      end
    end
    m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
  endtask

  // Reference model process
  initial begin
    forever begin
      @(posedge aclk or negedge aresetn);
      if (!aresetn) model_reset();
      else model_step(cyc);
      if (aclk) cyc++;
    end
  end

  // Monitor: pops the scoreboard on DUT events and checks per-cycle state
  initial begin
    exp_t e;
    int   t;
    forever begin
      @(negedge aclk);
      #1;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        n_cmp++; n_bad++;
        $display("FAIL start_missing: no tx_start, expected at cycle %0d sel %0d", e.cyc, e.sel);
      end
      while (tmo_q.size() > 0 && tmo_q[0] < cyc) begin
        t = tmo_q.pop_front();
        n_cmp++; n_bad++;
        $display("FAIL timeout_missing: no tx_timeout, expected at cycle %0d", t);
      end
      if (tx_start) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL start_unexpected: tx_start=1 with no pending grant, expected 0 (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          check("start_cycle", cyc, e.cyc);
          check("start_sel", int'(tx_sel), e.sel);
          if (e.sel == 2) begin
            check("start_id", int'(tx_icmp_id), e.id);
            check("start_seq", int'(tx_icmp_seq_num), e.seq);
          end
        end
      end
      if (tx_timeout) begin
        if (tmo_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL timeout_unexpected: tx_timeout=1, expected 0 (cycle %0d)", cyc);
        end else begin
          t = tmo_q.pop_front();
          check("timeout_cycle", cyc, t);
        end
      end
      check("sel_hold", int'(tx_sel), m_sel_now);
      if (m_sel_now == 2) begin
        check("id_hold", int'(tx_icmp_id), m_id_now);
        check("seq_hold", int'(tx_icmp_seq_num), m_seq_now);
      end
      check("icmp_pending", int'(icmp_pending), mq_id.size());
      check("drop_cnt", int'(drop_cnt), m_drop);
    end
  end

  // Builder stand-in: answers each tx_start according to done_mode
  initial begin
    int k;
    int r;
    bit abort;
    bit spur;
    forever begin
      @(negedge aclk);
      #1;
      if (tx_start && aresetn) begin
        spur = 1'b0;
        case (done_mode)
          0: k = done_fixed;
          1: k = 0;
          2: k = TMO - 1;
          default: begin
            r = int'($urandom_range(0, 15));
            if (r == 0) k = 0;
            else if (r == 1) k = TMO - 1;
            else if (r == 2) k = TMO;
            else k = 1 + int'($urandom_range(0, 19));
            spur = ($urandom_range(0, 3) == 0);
          end
        endcase
        if (k > 0) begin
          abort = 1'b0;
          for (int i = 0; i < k; i++) begin
            @(negedge aclk);
            if (!aresetn) abort = 1'b1;
          end
          if (!abort && aresetn) begin
            tx_done = 1'b1;
            @(negedge aclk);
            tx_done = 1'b0;
            if (spur) begin
              repeat (2) @(negedge aclk);
              tx_done = 1'b1;
              @(negedge aclk);
              tx_done = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic pulse(input bit a, input bit i, input logic [15:0] id, input logic [15:0] seq);
    @(negedge aclk);
    arp_reply_req = a;
    icmp_request_done = i;
    icmp_id = id;
    icmp_seq_num = seq;
    @(negedge aclk);
    arp_reply_req = 1'b0;
    icmp_request_done = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && tmo_q.size() == 0 && !m_busy && cyc > m_free_at &&
             !m_arp && mq_id.size() == 0)) begin
      if (n == budget) begin
        n_cmp++; n_bad++;
        $display("FAIL drain: scheduler still busy after %0d cycles, expected idle", budget);
        return;
      end
      @(negedge aclk);
      n++;
    end
  endtask

  initial begin
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    while (cyc < 9) @(negedge aclk);

    // Single ARP, then a second ARP while busy: second grant honours the gap
    done_mode = 0; done_fixed = 8;
    pulse(1'b1, 1'b0, 16'd0, 16'd0);
    repeat (3) @(negedge aclk);
    pulse(1'b1, 1'b0, 16'd0, 16'd0);
    wait_idle(200);

    // Single ICMP echo
    pulse(1'b0, 1'b1, 16'h1234, 16'h0001);
    wait_idle(200);

    // Dual load, repeated: ARP, ICMP, ARP, ICMP
    done_fixed = 3;
    pulse(1'b1, 1'b1, 16'hBEEF, 16'h0010);
    wait_idle(200);
    pulse(1'b1, 1'b1, 16'hBEEF, 16'h0011);
    wait_idle(200);

    // Five ICMP while the builder is busy: one drop, FIFO order seq 1..4
    done_fixed = 40;
    pulse(1'b1, 1'b0, 16'd0, 16'd0);
    for (int s = 1; s <= 5; s++) pulse(1'b0, 1'b1, 16'h00AA, 16'(s));
    wait_idle(800);

    // Never answered: both frames time out and the queue still advances
    done_mode = 1;
    pulse(1'b0, 1'b1, 16'h0101, 16'h0007);
    pulse(1'b0, 1'b1, 16'h0202, 16'h0008);
    wait_idle(400);

    // tx_done on the last cycle before timeout wins
    done_mode = 2;
    pulse(1'b1, 1'b0, 16'd0, 16'd0);
    wait_idle(400);

    // Reset in WAIT_DONE with three ICMP requests queued
    done_mode = 0; done_fixed = 40;
    pulse(1'b1, 1'b0, 16'd0, 16'd0);
    for (int i = 0; i < 50 && !m_busy; i++) @(negedge aclk);
    for (int s = 1; s <= 3; s++) pulse(1'b0, 1'b1, 16'h0C0C, 16'(s));
    @(negedge aclk);
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    repeat (40) @(negedge aclk);

    // Random traffic with mixed builder behaviour
    done_mode = 3;
    for (int i = 0; i < 4000; i++) begin
      @(negedge aclk);
      arp_reply_req = ($urandom_range(0, 11) == 0);
      icmp_request_done = ($urandom_range(0, 5) == 0);
      icmp_id = 16'($urandom);
      icmp_seq_num = 16'($urandom);
    end
    @(negedge aclk);
    arp_reply_req = 1'b0;
    icmp_request_done = 1'b0;
    wait_idle(3000);

    check("leftover_grants", exp_q.size(), 0);
    check("leftover_timeouts", tmo_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
